wb_rgb_pwm: RTL

Wishbone-slave RGB LED controller driving the board's led0 red/green/blue pins from the SoC. It replaces the free-running debug LED counter in the board top: software writes per-channel 8-bit duty values, and the block generates glitch-free PWM with a programmable prescaler. It is clocked from the PLL-derived slow_clk and reset by the combined button/PLL-lock reset.

---
 rtl/wb_rgb_pwm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/wb_rgb_pwm.sv
// rtl/wb_rgb_pwm.sv - Wishbone RGB LED PWM controller with shadowed duties and prescaler
// Optional blink register and blink gating are built when RGB_PWM_BLINK_EN is defined.
module wb_rgb_pwm #(
    parameter int PRESCALE_WIDTH = 16,
    parameter bit DEFAULT_ENABLE = 1'b0
) (
    input  logic        slow_clk,
    input  logic        reset,
    input  logic        wb_cyc_in,
    input  logic        wb_stb_in,
    input  logic        wb_we_in,
    input  logic [3:0]  wb_adr_in,
    input  logic [31:0] wb_dat_in,
    input  logic [3:0]  wb_sel_in,
    output logic [31:0] wb_dat_out,
    output logic        wb_ack_out,
    output logic        led_r_out,
    output logic        led_g_out,
    output logic        led_b_out
);

    logic                      enable;
    logic [PRESCALE_WIDTH-1:0] presc;
    logic [PRESCALE_WIDTH-1:0] pre_cnt;
    logic [7:0]                pwm_cnt;
    logic [23:0]               duty_shadow;
    logic [23:0]               duty_active;

    logic        req, wr, rd;
    logic [1:0]  reg_sel;
    logic [31:0] wmask;
    logic [31:0] ctrl_word, ctrl_next;
    logic [23:0] duty_next;
    logic [31:0] rdata;
    logic        ctrl_wr, duty_wr, presc_wr;
    logic        tick, wrap;
    logic        blink_off;
    logic        blink_phase;
    logic [15:0] half_period;

    // The ack itself masks the request so every strobe gets one single-cycle ack.
    assign req      = wb_cyc_in & wb_stb_in & ~wb_ack_out;
    assign wr       = req & wb_we_in;
    assign rd       = req & ~wb_we_in;
    assign reg_sel  = wb_adr_in[3:2];
    assign wmask    = {{8{wb_sel_in[3]}}, {8{wb_sel_in[2]}}, {8{wb_sel_in[1]}}, {8{wb_sel_in[0]}}};
    assign ctrl_wr  = wr && (reg_sel == 2'd0);
    assign duty_wr  = wr && (reg_sel == 2'd1);
    assign presc_wr = ctrl_wr && (|wb_sel_in[3:2]);

    assign tick = (pre_cnt == presc);
    assign wrap = tick && (pwm_cnt == 8'hFF);

    always_comb begin
        ctrl_word = '0;
        ctrl_word[0] = enable;
        ctrl_word[PRESCALE_WIDTH+15:16] = presc;
    end

    assign ctrl_next = (ctrl_word & ~wmask) | (wb_dat_in & wmask);
    assign duty_next = (duty_shadow & ~wmask[23:0]) | (wb_dat_in[23:0] & wmask[23:0]);

`ifdef RGB_PWM_BLINK_EN
    logic [15:0] blink_cnt;
    logic [15:0] half_next;
    logic        blink_wr;

    assign blink_wr  = wr && (reg_sel == 2'd2);
    assign half_next = (half_period & ~wmask[15:0]) | (wb_dat_in[15:0] & wmask[15:0]);
    assign blink_off = blink_phase & (half_period != 16'd0);

    always_ff @(posedge slow_clk) begin
        if (!reset) begin
            half_period <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_wr) begin
            half_period <= half_next;
            if (half_next == 16'd0) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end
        end else if (wrap && (half_period != 16'd0)) begin
            // Compare in 17 bits so a shrunk half_period still terminates the count.
            if (({1'b0, blink_cnt} + 17'd1) >= {1'b0, half_period}) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 16'd1;
            end
        end
    end
`else
    assign blink_off   = 1'b0;
    assign blink_phase = 1'b0;
    assign half_period = '0;
`endif

    always_comb begin
        rdata = '0;
        case (reg_sel)
            2'd0: rdata = ctrl_word;
            2'd1: rdata = {8'h00, duty_shadow};
            2'd2: rdata = {16'h0000, half_period};
            2'd3: rdata = {23'h0, blink_phase, pwm_cnt};
            default: rdata = '0;
        endcase
    end

    always_ff @(posedge slow_clk) begin
        if (!reset) begin
            wb_ack_out  <= 1'b0;
            wb_dat_out  <= '0;
            enable      <= DEFAULT_ENABLE;
            presc       <= '0;
            pre_cnt     <= '0;
            pwm_cnt     <= '0;
            duty_shadow <= '0;
            duty_active <= '0;
            led_r_out   <= 1'b0;
            led_g_out   <= 1'b0;
            led_b_out   <= 1'b0;
        end else begin
            wb_ack_out <= req;
            wb_dat_out <= rd ? rdata : 32'h0;
            if (ctrl_wr) begin
                enable <= ctrl_next[0];
                presc  <= ctrl_next[PRESCALE_WIDTH+15:16];
            end
            if (duty_wr)
                duty_shadow <= duty_next;
            if (presc_wr || tick)
                pre_cnt <= '0;
            else
                pre_cnt <= pre_cnt + PRESCALE_WIDTH'(1);
            if (tick)
                pwm_cnt <= pwm_cnt + 8'd1;
            // Loading only at the period boundary keeps every period whole.
            if (wrap)
                duty_active <= duty_shadow;
            led_r_out <= enable & (pwm_cnt < duty_active[7:0])   & ~blink_off;
            led_g_out <= enable & (pwm_cnt < duty_active[15:8])  & ~blink_off;
            led_b_out <= enable & (pwm_cnt < duty_active[23:16]) & ~blink_off;
        end
    end

    logic unused_bits;
    assign unused_bits = &{1'b0, wb_adr_in[1:0], ctrl_next, wb_dat_in};

endmodule
